// File: rtl/ctr_keystream_gen.sv
// CTR-mode keystream combiner: builds {nonce, ctr} counter blocks for an external AES core
// and XORs the returned keystream with one captured data block at a time.
module ctr_keystream_gen #(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [95:0]  nonce_i,
    input  logic [31:0]  ctr_init_i,
    input  logic         load_i,
    input  logic [127:0] data_i,
    input  logic         data_valid_i,
    output logic         data_ready_o,
    output logic [127:0] aes_block_o,
    output logic         aes_start_o,
    input  logic         aes_done_i,
    input  logic [127:0] aes_result_i,
    output logic [127:0] out_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [31:0]  ctr_o,
    output logic         wrap_o,
    output logic         err_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [95:0]    nonce_q, nonce_d;
    logic [31:0]    ctr_q, ctr_d;
    logic [127:0]   data_q, data_d;
    logic [127:0]   block_q, block_d;
    logic           start_q, start_d;
    logic [127:0]   out_q, out_d;
    logic           out_valid_q, out_valid_d;
    logic           wrap_q, wrap_d;
    logic           err_q, err_d;
    logic           ready_q, ready_d;
    logic [TW-1:0]  tmo_q, tmo_d;

    // Next-state and datapath update for the IDLE/REQ/WAIT/OUT sequence.
    always_comb begin
        state_d     = state_q;
        nonce_d     = nonce_q;
        ctr_d       = ctr_q;
        data_d      = data_q;
        block_d     = block_q;
        start_d     = 1'b0;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        wrap_d      = wrap_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        case (state_q)
            S_IDLE: begin
                // A load wins over data presented in the same cycle.
                if (load_i) begin
                    nonce_d = nonce_i;
                    ctr_d   = ctr_init_i;
                    wrap_d  = 1'b0;
                    err_d   = 1'b0;
                end else if (data_valid_i) begin
                    data_d  = data_i;
                    block_d = {nonce_q, ctr_q};
                    start_d = 1'b1;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done is checked first so it beats a timeout in the same cycle.
                if (aes_done_i) begin
                    out_d       = data_q ^ aes_result_i;
                    out_valid_d = 1'b1;
                    ctr_d       = ctr_q + 32'd1;
                    if (ctr_q == 32'hFFFF_FFFF) begin
                        wrap_d = 1'b1;
                    end else begin
                        wrap_d = wrap_q;
                    end
                    state_d = S_OUT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            nonce_q     <= 96'd0;
            ctr_q       <= 32'd0;
            data_q      <= 128'd0;
            block_q     <= 128'd0;
            start_q     <= 1'b0;
            out_q       <= 128'd0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            nonce_q     <= nonce_d;
            ctr_q       <= ctr_d;
            data_q      <= data_d;
            block_q     <= block_d;
            start_q     <= start_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            tmo_q       <= tmo_d;
        end
    end

    assign data_ready_o = ready_q;
    assign aes_block_o  = block_q;
    assign aes_start_o  = start_q;
    assign out_o        = out_q;
    assign out_valid_o  = out_valid_q;
    assign ctr_o        = ctr_q;
    assign wrap_o       = wrap_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_ctr_keystream_gen.sv
// Bench for ctr_keystream_gen: a vector table with an expected-output queue on the default
// instance, plus a second instance with a short timeout for the abort/priority corners.
module tb_ctr_keystream_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic [95:0]  nonce_i;
    logic [31:0]  ctr_init_i;
    logic [127:0] data_i, aes_result_i, t_res;
    logic         load_i, data_valid_i, aes_done_i, out_ready_i;
    logic         t_load, t_dv, t_done, t_ready;

    logic         data_ready_o, aes_start_o, out_valid_o, wrap_o, err_o;
    logic [127:0] aes_block_o, out_o;
    logic [31:0]  ctr_o;
    logic         t_data_ready, t_start, t_out_valid, t_wrap, t_err;
    logic [127:0] t_block, t_out;
    logic [31:0]  t_ctr;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int exp_starts = 0;
    logic t_ov_seen = 1'b0;
    logic [127:0] sb_q[$];
    logic [95:0]  cur_nonce;
    logic [31:0]  cur_ctr;

    always #5 clk = ~clk;

    ctr_keystream_gen dut (
        .clk(clk), .rst(rst), .nonce_i(nonce_i), .ctr_init_i(ctr_init_i), .load_i(load_i),
        .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
        .aes_block_o(aes_block_o), .aes_start_o(aes_start_o), .aes_done_i(aes_done_i),
        .aes_result_i(aes_result_i), .out_o(out_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .ctr_o(ctr_o), .wrap_o(wrap_o), .err_o(err_o)
    );

    ctr_keystream_gen #(.TIMEOUT_CYC(8)) dut_t (
        .clk(clk), .rst(rst), .nonce_i(nonce_i), .ctr_init_i(ctr_init_i), .load_i(t_load),
        .data_i(data_i), .data_valid_i(t_dv), .data_ready_o(t_data_ready),
        .aes_block_o(t_block), .aes_start_o(t_start), .aes_done_i(t_done),
        .aes_result_i(t_res), .out_o(t_out), .out_valid_o(t_out_valid),
        .out_ready_i(t_ready), .ctr_o(t_ctr), .wrap_o(t_wrap), .err_o(t_err)
    );

    always @(negedge clk) begin
        if (aes_start_o === 1'b1) start_cnt++;
        if (t_out_valid === 1'b1) t_ov_seen <= 1'b1;
    end

    typedef struct {
        logic         do_load;
        logic [95:0]  nonce;
        logic [31:0]  ctr;
        logic [127:0] data;
        logic [127:0] ks;
        int           lat;
        int           hold;
        logic [127:0] exp_out;
        logic [31:0]  exp_ctr;
        logic         exp_wrap;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [95:0] n, input logic [31:0] c);
        nonce_i = n; ctr_init_i = c; load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        cur_nonce = n; cur_ctr = c;
        chk("load_state", {ctr_o, wrap_o, err_o, data_ready_o}, {c, 1'b0, 1'b0, 1'b1});
    endtask

    // Send one block, answer from the stub after lat WAIT cycles, hold output for hold cycles.
    task automatic run_block(input logic [127:0] d, input logic [127:0] ks, input int lat,
                             input int hold, input logic [127:0] exp_out, input bit busy_load);
        logic [127:0] exp_block;
        logic [127:0] got;
        exp_block = {cur_nonce, cur_ctr};
        data_i = d; data_valid_i = 1'b1;
        sb_q.push_back(exp_out);
        exp_starts++;
        @(negedge clk);
        data_valid_i = 1'b0;
        chk("start_req", {aes_start_o, data_ready_o, aes_block_o}, {1'b1, 1'b0, exp_block});
        @(negedge clk);
        chk("start_once", {aes_start_o, out_valid_o}, {1'b0, 1'b0});
        if (busy_load) begin
            nonce_i = 96'hdead; ctr_init_i = 32'h0000_0050; load_i = 1'b1;
        end
        for (int i = 1; i < lat; i++) @(negedge clk);
        load_i = 1'b0;
        chk("block_stable", aes_block_o, exp_block);
        aes_done_i = 1'b1; aes_result_i = ks;
        @(negedge clk);
        aes_done_i = 1'b0; aes_result_i = ~ks;
        chk("out_valid_latency", {out_valid_o, data_ready_o}, {1'b1, 1'b0});
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1'b1, 1'b0);
        end else begin
            got = sb_q.pop_front();
            chk("out_data", out_o, got);
        end
        data_valid_i = (hold > 0);
        data_i = ~d;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("backpressure", {out_valid_o, data_ready_o, aes_start_o, out_o},
                {1'b1, 1'b0, 1'b0, exp_out});
        end
        data_valid_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        chk("drain", {out_valid_o, data_ready_o, aes_start_o}, {1'b1 ^ 1'b1, 1'b1, 1'b0});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 96'h0, 32'h0000_0001, 128'hffeeddccbbaa99887766554433221102,
                    128'h00112233445566778899aabbccddeeff, 15, 0,
                    128'hfffffffffffffffffffffffffffffffd, 32'h0000_0002, 1'b0};
        vecs[1] = '{1'b0, 96'h0, 32'h0, 128'h0123456789abcdef0f1e2d3c4b5a6978,
                    128'hdeadbeefcafef00d1122334455667788, 1, 10,
                    128'h0123456789abcdef0f1e2d3c4b5a6978 ^ 128'hdeadbeefcafef00d1122334455667788,
                    32'h0000_0003, 1'b0};
        vecs[2] = '{1'b1, 96'hcafebabe_00000000_12345678, 32'hFFFF_FFFF,
                    {4{32'h5555_5555}}, {4{32'haaaa_aaaa}}, 3, 2,
                    {4{32'hffff_ffff}}, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b0, 96'h0, 32'h0, 128'h0, 128'h13579bdf02468ace_fedcba9876543210, 2, 0,
                    128'h13579bdf02468ace_fedcba9876543210, 32'h0000_0001, 1'b1};
        vecs[4] = '{1'b1, 96'h1, 32'h0000_0020, {4{32'hffff_ffff}}, {4{32'h0f0f_0f0f}}, 4, 1,
                    {4{32'hf0f0_f0f0}}, 32'h0000_0021, 1'b0};

        rst = 1'b1;
        nonce_i = 96'h0; ctr_init_i = 32'h0; data_i = 128'h0; aes_result_i = 128'h0;
        load_i = 1'b0; data_valid_i = 1'b0; aes_done_i = 1'b0; out_ready_i = 1'b0;
        t_load = 1'b0; t_dv = 1'b0; t_done = 1'b0; t_ready = 1'b0; t_res = 128'h0;
        cur_nonce = 96'h0; cur_ctr = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_vals", {aes_block_o, ctr_o, aes_start_o, out_valid_o, wrap_o, err_o},
            {128'h0, 32'h0, 4'h0});
        chk("reset_out", out_o, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", data_ready_o, 1'b1);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].do_load) do_load(vecs[i].nonce, vecs[i].ctr);
            run_block(vecs[i].data, vecs[i].ks, vecs[i].lat, vecs[i].hold, vecs[i].exp_out, 1'b0);
            cur_ctr = vecs[i].exp_ctr;
            chk($sformatf("vec%0d_ctr_wrap", i), {ctr_o, wrap_o}, {vecs[i].exp_ctr, vecs[i].exp_wrap});
        end

        // Load during WAIT is ignored: counter continues from 0x21.
        run_block(128'h77, 128'h11, 4, 0, 128'h66, 1'b1);
        chk("busy_load_ctr", {ctr_o, wrap_o}, {32'h0000_0022, 1'b0});

        // Load and data together in IDLE: load taken, data dropped.
        nonce_i = 96'h3; ctr_init_i = 32'h0000_0040; load_i = 1'b1;
        data_i = 128'h9; data_valid_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0; data_valid_i = 1'b0;
        chk("load_wins", {ctr_o, data_ready_o, aes_start_o}, {32'h0000_0040, 1'b1, 1'b0});
        @(negedge clk);
        chk("load_wins_nostart", {aes_start_o, data_ready_o}, {1'b0, 1'b1});

        // Stray done in IDLE changes nothing.
        aes_done_i = 1'b1; aes_result_i = 128'h5;
        @(negedge clk);
        aes_done_i = 1'b0;
        chk("done_idle", {out_valid_o, ctr_o, data_ready_o}, {1'b0, 32'h0000_0040, 1'b1});

        // Timeout on the short-timeout instance; stub never answers.
        nonce_i = 96'habc; ctr_init_i = 32'h0000_0077; t_load = 1'b1;
        @(negedge clk);
        t_load = 1'b0; t_dv = 1'b1; data_i = 128'h1234;
        @(negedge clk);
        t_dv = 1'b0;
        repeat (8) @(negedge clk);
        chk("tmo_not_yet", {t_err, t_data_ready}, {1'b0, 1'b0});
        @(negedge clk);
        chk("tmo_abort", {t_err, t_data_ready, t_ctr, t_ov_seen}, {1'b1, 1'b1, 32'h0000_0077, 1'b0});

        // Done on the last timeout cycle takes priority.
        t_load = 1'b1;
        @(negedge clk);
        t_load = 1'b0;
        chk("tmo_load_clears", t_err, 1'b0);
        t_dv = 1'b1; data_i = 128'hf0;
        @(negedge clk);
        t_dv = 1'b0;
        repeat (8) @(negedge clk);
        t_done = 1'b1; t_res = 128'h0f;
        @(negedge clk);
        t_done = 1'b0;
        chk("done_prio", {t_out_valid, t_err, t_ctr, t_out}, {1'b1, 1'b0, 32'h0000_0078, 128'hff});
        t_ready = 1'b1;
        @(negedge clk);
        t_ready = 1'b0;

        // Reset mid-WAIT, then a late done is ignored.
        data_i = 128'h42; data_valid_i = 1'b1;
        exp_starts++;
        @(negedge clk);
        data_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_wait", {aes_block_o, ctr_o, aes_start_o, out_valid_o, wrap_o, err_o},
            {128'h0, 32'h0, 4'h0});
        @(negedge clk);
        rst = 1'b0;
        aes_done_i = 1'b1; aes_result_i = 128'h99;
        @(negedge clk);
        aes_done_i = 1'b0;
        chk("rst_late_done", {out_valid_o, data_ready_o, out_o, ctr_o},
            {1'b0, 1'b1, 128'h0, 32'h0});
        @(negedge clk);
        chk("start_pulse_count", start_cnt, exp_starts);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
